// File: rtl/hydra_vol_pkg.sv
// Shared types and helpers for the volume compositing pipeline.
// Holds the compositor state encoding, the RGB struct and the front-to-back weight function.
package hydra_vol_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  localparam logic [7:0] DEF_ALPHA_THRESH = 8'd250;

  // Contribution weight of a sample: remaining transmittance times sample opacity.
  function automatic logic [7:0] comp_weight(input logic [7:0] acc_a, input logic [7:0] a);
    logic [15:0] prod;
    prod = {8'd0, 8'd255 - acc_a} * {8'd0, a};
    return 8'(prod >> 8);
  endfunction

endpackage

// File: rtl/composite_mac.sv
// One colour channel of the compositor: sum = min(255, acc + (w * c) >> 8).
// Used both for accumulating samples and for blending the background behind the ray.
module composite_mac (
  input  logic [7:0] w,
  input  logic [7:0] c,
  input  logic [7:0] acc,
  output logic [7:0] sum
);

  logic [15:0] prod;
  logic [8:0]  total;

  always_comb begin
    prod  = {8'd0, w} * {8'd0, c};
    total = {1'b0, acc} + 9'(prod >> 8);
    sum   = total[8] ? 8'hFF : total[7:0];
  end

endmodule

// File: rtl/ray_compositor.sv
// Front-to-back compositor for one ray at a time: accumulates premultiplied colour and
// opacity, flags early termination to the marcher and emits one pixel per ray.
module ray_compositor
  import hydra_vol_pkg::*;
#(
  parameter logic [7:0]  ALPHA_THRESH = DEF_ALPHA_THRESH,
  parameter logic [23:0] BG_COLOR     = 24'h000000,
  parameter int          ID_W         = 16,
  parameter int          CNT_W        = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ray_start,
  input  logic [ID_W-1:0]  ray_id,
  output logic             ray_ready,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic [23:0]      sample_color,
  input  logic [7:0]       sample_density,
  input  logic             sample_last,
  output logic             ray_term,
  output logic             pixel_valid,
  input  logic             pixel_ready,
  output logic [23:0]      pixel_color,
  output logic [7:0]       pixel_alpha,
  output logic [ID_W-1:0]  pixel_id,
  output logic [CNT_W-1:0] pixel_count,
  output logic             pixel_early,
  output state_t           dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where both valid and ready are
  // high; the producer holds valid and data steady until then.

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  rgb8_t            acc, acc_mac, blend, samp, bg;
  logic [7:0]       acc_a, w, tr, new_a;
  logic [CNT_W-1:0] count;
  logic             early, hit, accum_en, term_set, ray_term_q;
  logic [ID_W-1:0]  id_q;

  assign samp  = rgb8_t'(sample_color);
  assign bg    = rgb8_t'(BG_COLOR);
  assign w     = comp_weight(acc_a, sample_density);
  assign new_a = acc_a + w;
  assign hit   = (new_a >= ALPHA_THRESH);
  assign tr    = 8'd255 - acc_a;

  composite_mac u_mac_r (.w(w), .c(samp.r), .acc(acc.r), .sum(acc_mac.r));
  composite_mac u_mac_g (.w(w), .c(samp.g), .acc(acc.g), .sum(acc_mac.g));
  composite_mac u_mac_b (.w(w), .c(samp.b), .acc(acc.b), .sum(acc_mac.b));

  // Background shows through whatever transmittance remains at the end of the ray.
  composite_mac u_bg_r (.w(tr), .c(bg.r), .acc(acc.r), .sum(blend.r));
  composite_mac u_bg_g (.w(tr), .c(bg.g), .acc(acc.g), .sum(blend.g));
  composite_mac u_bg_b (.w(tr), .c(bg.b), .acc(acc.b), .sum(blend.b));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ray_ready    = 1'b0;
    sample_ready = 1'b0;
    pixel_valid  = 1'b0;
    accum_en     = 1'b0;
    term_set     = 1'b0;
    case (state)
      IDLE: begin
        ray_ready = 1'b1;
        if (ray_start) state_nxt = ACCUM;
      end
      ACCUM: begin
        sample_ready = 1'b1;
        if (sample_valid) begin
          accum_en = 1'b1;
          if (hit) begin
            term_set  = !sample_last;
            state_nxt = sample_last ? OUT : DRAIN;
          end else if (sample_last) begin
            state_nxt = OUT;
          end
        end
      end
      DRAIN: begin
        sample_ready = 1'b1;
        if (sample_valid && sample_last) state_nxt = OUT;
      end
      OUT: begin
        pixel_valid = 1'b1;
        if (pixel_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      acc_a      <= '0;
      count      <= '0;
      early      <= 1'b0;
      id_q       <= '0;
      ray_term_q <= 1'b0;
    end else begin
      ray_term_q <= term_set;
      if (state == IDLE && ray_start) begin
        acc   <= '0;
        acc_a <= '0;
        count <= '0;
        early <= 1'b0;
        id_q  <= ray_id;
      end else if (accum_en) begin
        acc   <= acc_mac;
        acc_a <= new_a;
        if (count != CNT_MAX) count <= count + 1'b1;
        if (hit) early <= 1'b1;
      end
    end
  end

  // Pixel fields read as zero whenever no pixel is being offered.
  assign ray_term    = ray_term_q;
  assign pixel_color = pixel_valid ? blend : 24'd0;
  assign pixel_alpha = pixel_valid ? acc_a : 8'd0;
  assign pixel_id    = pixel_valid ? id_q  : '0;
  assign pixel_count = pixel_valid ? count : '0;
  assign pixel_early = pixel_valid & early;
  assign dbg_state   = state;

endmodule

// File: tb/tb_ray_compositor.sv
// Self-checking bench for ray_compositor: directed and random rays against a ray-level
// model, with a second instance using a blue background to exercise the blend path.
module tb_ray_compositor;
  import hydra_vol_pkg::*;

  localparam int ID_W = 16;
  localparam int CNT_W = 12;
  localparam logic [23:0] BG_A = 24'h000000;
  localparam logic [23:0] BG_B = 24'h0000FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ray_start = 1'b0;
  logic [ID_W-1:0] ray_id = '0;
  logic sample_valid = 1'b0;
  logic [23:0] sample_color = '0;
  logic [7:0] sample_density = '0;
  logic sample_last = 1'b0;
  logic pixel_ready = 1'b0;

  logic ray_ready, sample_ready, ray_term, pixel_valid, pixel_early;
  logic [23:0] pixel_color;
  logic [7:0] pixel_alpha;
  logic [ID_W-1:0] pixel_id;
  logic [CNT_W-1:0] pixel_count;
  state_t dbg_state;

  logic ray_ready2, sample_ready2, ray_term2, pixel_valid2, pixel_early2;
  logic [23:0] pixel_color2;
  logic [7:0] pixel_alpha2;
  logic [ID_W-1:0] pixel_id2;
  logic [CNT_W-1:0] pixel_count2;
  state_t dbg_state2;

  ray_compositor #(.BG_COLOR(BG_A), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ray_start(ray_start), .ray_id(ray_id), .ray_ready(ray_ready),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_color(sample_color),
    .sample_density(sample_density), .sample_last(sample_last), .ray_term(ray_term),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_color(pixel_color),
    .pixel_alpha(pixel_alpha), .pixel_id(pixel_id), .pixel_count(pixel_count),
    .pixel_early(pixel_early), .dbg_state(dbg_state)
  );

  ray_compositor #(.BG_COLOR(BG_B), .ID_W(ID_W), .CNT_W(CNT_W)) dut_bg (
    .clk(clk), .rst(rst), .ray_start(ray_start), .ray_id(ray_id), .ray_ready(ray_ready2),
    .sample_valid(sample_valid), .sample_ready(sample_ready2), .sample_color(sample_color),
    .sample_density(sample_density), .sample_last(sample_last), .ray_term(ray_term2),
    .pixel_valid(pixel_valid2), .pixel_ready(pixel_ready), .pixel_color(pixel_color2),
    .pixel_alpha(pixel_alpha2), .pixel_id(pixel_id2), .pixel_count(pixel_count2),
    .pixel_early(pixel_early2), .dbg_state(dbg_state2)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int term_cnt = 0;

  always @(negedge clk) if (ray_term) term_cnt++;

  // ---------------- scoreboard ----------------
  logic [60:0] exp_q[$];
  logic [23:0] exp2_q[$];
  logic [7:0]  s_dens[$];
  logic [23:0] s_col[$];

  logic [23:0] obs_color, obs_color2;
  logic [7:0]  obs_alpha;
  logic [11:0] obs_count;
  logic        obs_early;

  typedef struct {
    logic [23:0] color;
    logic [23:0] color2;
    logic [7:0]  alpha;
    logic [11:0] count;
    logic        early;
    int          term_idx;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'd255 : v[7:0];
  endfunction

  // Ray-level reference: walk the sample list, stop contributing once the threshold is hit.
  function automatic exp_t model();
    exp_t e;
    int r, g, b, a, cnt, wgt, n;
    bit done;
    r = 0; g = 0; b = 0; a = 0; cnt = 0; done = 0;
    n = s_dens.size();
    e.early = 1'b0;
    e.term_idx = -1;
    for (int i = 0; i < n; i++) begin
      if (!done) begin
        wgt = ((255 - a) * int'(s_dens[i])) / 256;
        r = int'(sat8(r + (wgt * int'(s_col[i][23:16])) / 256));
        g = int'(sat8(g + (wgt * int'(s_col[i][15:8])) / 256));
        b = int'(sat8(b + (wgt * int'(s_col[i][7:0])) / 256));
        a = a + wgt;
        if (cnt < 4095) cnt++;
        if (a >= 250) begin
          e.early = 1'b1;
          done = 1;
          if (i != n - 1) e.term_idx = i;
        end
      end
    end
    e.alpha = a[7:0];
    e.count = cnt[11:0];
    e.color = {sat8(r + ((255 - a) * int'(BG_A[23:16])) / 256),
               sat8(g + ((255 - a) * int'(BG_A[15:8])) / 256),
               sat8(b + ((255 - a) * int'(BG_A[7:0])) / 256)};
    e.color2 = {sat8(r + ((255 - a) * int'(BG_B[23:16])) / 256),
                sat8(g + ((255 - a) * int'(BG_B[15:8])) / 256),
                sat8(b + ((255 - a) * int'(BG_B[7:0])) / 256)};
    return e;
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_ray(input logic [ID_W-1:0] id);
    int guard;
    guard = 0;
    while (!ray_ready && guard < 50) begin step(); guard++; end
    chk("ray_ready_before_start", 64'(ray_ready), 64'd1);
    ray_start = 1'b1;
    ray_id = id;
    step();
    ray_start = 1'b0;
    chk("sample_ready_after_start", 64'(sample_ready), 64'd1);
  endtask

  // Offer one sample and hold it until accepted; returns once the accepting edge has passed.
  task automatic send_sample(input logic [7:0] d, input logic [23:0] c, input logic last,
                             input int gap_max);
    int guard;
    bit took;
    repeat ($urandom_range(0, gap_max)) step();
    sample_valid = 1'b1;
    sample_density = d;
    sample_color = c;
    sample_last = last;
    guard = 0;
    took = 0;
    while (!took && guard < 50) begin
      took = sample_ready;
      step();
      guard++;
    end
    if (!took) chk("sample_accept_timeout", 64'd0, 64'd1);
    sample_valid = 1'b0;
    sample_last = 1'b0;
  endtask

  task automatic run_ray(input logic [ID_W-1:0] id, input int hold, input int gap_max);
    exp_t e;
    int n;
    logic [60:0] expv;
    n = s_dens.size();
    e = model();
    exp_q.push_back({id, e.count, e.early, e.alpha, e.color});
    exp2_q.push_back(e.color2);
    start_ray(id);
    term_cnt = 0;
    for (int i = 0; i < n; i++) begin
      send_sample(s_dens[i], s_col[i], (i == n - 1), gap_max);
      if (i == e.term_idx) chk("ray_term_pulse", 64'(ray_term), 64'd1);
    end
    chk("pixel_valid_after_last", 64'(pixel_valid), 64'd1);
    expv = exp_q.pop_front();
    pixel_ready = 1'b0;
    ray_start = 1'b1;
    ray_id = ~id;
    for (int k = 0; k < hold; k++) begin
      chk("hold_valid", 64'(pixel_valid), 64'd1);
      chk("hold_pixel", 64'({pixel_id, pixel_count, pixel_early, pixel_alpha, pixel_color}),
          64'(expv));
      step();
    end
    obs_color = pixel_color;
    obs_color2 = pixel_color2;
    obs_alpha = pixel_alpha;
    obs_count = pixel_count;
    obs_early = pixel_early;
    chk("pixel_fields", 64'({pixel_id, pixel_count, pixel_early, pixel_alpha, pixel_color}),
        64'(expv));
    chk("pixel_color_bg", 64'(pixel_color2), 64'(exp2_q.pop_front()));
    pixel_ready = 1'b1;
    step();
    pixel_ready = 1'b0;
    ray_start = 1'b0;
    chk("ray_ready_after_handshake", 64'({ray_ready, pixel_valid, sample_ready}), 64'b100);
    chk("ray_term_count", 64'(term_cnt), 64'(e.term_idx >= 0 ? 1 : 0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 64'({ray_ready, sample_ready, ray_term, pixel_valid}), 64'b1000);
    chk({tag, "_pix"}, 64'({pixel_color, pixel_alpha, pixel_id, pixel_count, pixel_early}),
        64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    repeat (3) step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Opaque first sample terminates early; remaining samples drained.
    s_dens = '{8'd255, 8'd90, 8'd200, 8'd17};
    s_col = '{24'hFF8040, 24'h123456, 24'hFFFFFF, 24'hABCDEF};
    run_ray(16'h0001, 0, 0);
    chk("t1_color", 64'(obs_color), 64'h00FD7F3F);
    chk("t1_alpha_count_early", 64'({obs_alpha, obs_count, obs_early}), 64'({8'd254, 12'd1, 1'b1}));

    // Two half-density samples with 5 cycles of pixel backpressure.
    s_dens = '{8'd128, 8'd128};
    s_col = '{24'h808080, 24'h808080};
    run_ray(16'h0002, 5, 1);
    chk("t2_color", 64'(obs_color), 64'h005F5F5F);
    chk("t2_alpha_count_early", 64'({obs_alpha, obs_count, obs_early}), 64'({8'd191, 12'd2, 1'b0}));

    // Transparent sample: only the background shows.
    s_dens = '{8'd0};
    s_col = '{24'hFFFFFF};
    run_ray(16'h0003, 1, 0);
    chk("t3_bg_color", 64'(obs_color2), 64'h000000FE);
    chk("t3_alpha_count", 64'({obs_alpha, obs_count}), 64'({8'd0, 12'd1}));

    // Terminating sample is also the last one: straight to OUT, no ray_term.
    s_dens = '{8'd255};
    s_col = '{24'h20FF10};
    run_ray(16'h0004, 2, 0);
    chk("t5_early", 64'(obs_early), 64'd1);

    // Reset in the middle of accumulation.
    start_ray(16'h00AA);
    send_sample(8'd100, 24'hFFFFFF, 1'b0, 0);
    send_sample(8'd100, 24'hFFFFFF, 1'b0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midray_rst");
    s_dens = '{8'd128};
    s_col = '{24'h808080};
    run_ray(16'h0005, 0, 0);
    chk("t6_fresh_color", 64'({obs_color, obs_alpha}), 64'({24'h3F3F3F, 8'd127}));

    // Random rays.
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(1, 6);
      s_dens = {};
      s_col = {};
      for (int i = 0; i < n; i++) begin
        s_dens.push_back(($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255)));
        s_col.push_back(24'($urandom));
      end
      run_ray(16'($urandom), $urandom_range(0, 3), 2);
    end

    // Sample counter saturation with a long transparent ray.
    s_dens = {};
    s_col = {};
    for (int i = 0; i < 4100; i++) begin
      s_dens.push_back(8'd0);
      s_col.push_back(24'($urandom));
    end
    run_ray(16'hBEEF, 0, 0);
    chk("count_saturated", 64'(obs_count), 64'h0FFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
